ahb_bus_ctrl: RTL

AHB_BUS_CTRL -- requirements
Module: ahb_bus_ctrl

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_bus_ctrl_arbiter.sv | 44 ++++
 rtl/ahb_bus_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the multi-manager bus controller.
// Transfer/burst encodings follow AMBA AHB; FSM states are prefixed S_.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_OWN  = 2'd2
  } state_t;

  // Remaining SEQ beats after the NONSEQ of a burst.
  function automatic logic [4:0] beat_load(
    input logic [2:0] b
  );
    case (b)
      INCR4, WRAP4:   return 5'd3;
      INCR8, WRAP8:   return 5'd7;
      INCR16, WRAP16: return 5'd15;
      default:        return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_ctrl_arbiter.sv
// Round-robin arbiter: grants the first requester after the last
// winner whenever enabled; the pointer advances only on a grant.
module ahb_bus_ctrl_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic [N-1:0] requestV_i,
  output logic [N-1:0] grantedV_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    grantedV_o = '0;
    last_d     = last_q;
    found      = 1'b0;
    j          = '0;
    if (enable_i) begin
      for (int k = 1; k <= N; k++) begin
        j = IW'((int'(last_q) + k) % N);
        if (!found && requestV_i[j]) begin
          found         = 1'b1;
          grantedV_o[j] = 1'b1;
          last_d        = j;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ahb_bus_ctrl.sv
// Multi-manager AHB bus controller: arbitration FSM, burst tracking
// and address/data-phase muxing onto a single subordinate port.
module ahb_bus_ctrl
  import ahb_pkg::*;
#(
  parameter int MANAGERS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [MANAGERS-1:0]                m_hbusreq,
  input  logic [MANAGERS-1:0][ADDR_W-1:0]    m_haddr,
  input  logic [MANAGERS-1:0][1:0]           m_htrans,
  input  logic [MANAGERS-1:0]                m_hwrite,
  input  logic [MANAGERS-1:0][2:0]           m_hsize,
  input  logic [MANAGERS-1:0][2:0]           m_hburst,
  input  logic [MANAGERS-1:0][DATA_W-1:0]    m_hwdata,
  output logic [MANAGERS-1:0]                m_hgrant,
  output logic                               m_hready,
  output logic [DATA_W-1:0]                  m_hrdata,
  output logic                               m_hresp,
  output logic [ADDR_W-1:0]                  s_haddr,
  output logic [1:0]                         s_htrans,
  output logic                               s_hwrite,
  output logic [2:0]                         s_hsize,
  output logic [2:0]                         s_hburst,
  output logic [DATA_W-1:0]                  s_hwdata,
  input  logic                               s_hreadyout,
  input  logic [DATA_W-1:0]                  s_hrdata,
  input  logic                               s_hresp
);

  localparam int IW = (MANAGERS > 1) ? $clog2(MANAGERS) : 1;

  state_t              state_q, state_d;
  logic [MANAGERS-1:0] owner_q, owner_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                arb_en_q, arb_en_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [IW-1:0]       dp_idx_q;
  logic                dp_vld_q;

  logic [MANAGERS-1:0] grant;
  logic [IW-1:0]       gidx;
  logic                is_nseq, is_seq;
  logic                accept, own_req, rel;

  ahb_bus_ctrl_arbiter #(
    .N (MANAGERS)
  ) u_arb (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .enable_i   (arb_en_q),
    .requestV_i (m_hbusreq),
    .grantedV_o (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < MANAGERS; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
  end

  always_comb begin
    m_hgrant = '0;
    s_haddr  = '0;
    s_htrans = IDLE;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hburst = '0;
    if (state_q == S_OWN) begin
      m_hgrant = owner_q;
      s_haddr  = m_haddr[idx_q];
      s_htrans = m_htrans[idx_q];
      s_hwrite = m_hwrite[idx_q];
      s_hsize  = m_hsize[idx_q];
      s_hburst = m_hburst[idx_q];
    end
  end

  assign s_hwdata = dp_vld_q ? m_hwdata[dp_idx_q] : '0;
  assign m_hready = s_hreadyout;
  assign m_hrdata = s_hrdata;
  assign m_hresp  = s_hresp;

  assign is_nseq = (s_htrans == NONSEQ);
  assign is_seq  = (s_htrans == SEQ);
  assign accept  = s_hreadyout && (is_nseq || is_seq);
  assign own_req = m_hbusreq[idx_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|m_hbusreq && s_hreadyout) state_d = S_ARB;
      end
      S_ARB: begin
        if (|grant) begin
          owner_d = grant;
          idx_d   = gidx;
          state_d = S_OWN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (accept && is_nseq) begin
          cnt_d = beat_load(s_hburst);
        end else if (accept) begin
          cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
        end
        rel = (accept && is_nseq && s_hburst == SINGLE)
           || (accept && is_seq && cnt_q == 5'd1)
           || (accept && s_hburst == INCR && !own_req)
           || (s_hreadyout && s_htrans == IDLE && !own_req);
        if (rel) state_d = (|m_hbusreq) ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    arb_en_d = (state_d == S_ARB);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      idx_q    <= '0;
      arb_en_q <= 1'b0;
      cnt_q    <= '0;
      dp_idx_q <= '0;
      dp_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      idx_q    <= idx_d;
      arb_en_q <= arb_en_d;
      cnt_q    <= cnt_d;
      // Data phase advances only when the subordinate completes a cycle.
      if (s_hreadyout) begin
        dp_idx_q <= idx_q;
        dp_vld_q <= (state_q == S_OWN) && (is_nseq || is_seq);
      end
    end
  end

endmodule
